wb_lfsr_initiator: RTL and testbench
====================================

Name: wb_lfsr_initiator

Overview:
- Wishbone pipelined-mode initiator that drives the LFSR peripheral's responder port.
- Accepts single commands from a local command port.
  - A write command issues one Wishbone write, e.g. to load the seed or control register.
  - A read command issues WORD_BITS back-to-back single-bit reads and assembles them into a word.
- Returns one response per command, with a per-transaction ack timeout.
- Sits between on-chip control logic and the LFSR block; one outstanding transaction at a time.

Parameters:
- WORD_BITS, 8, number of 1-bit Wishbone reads assembled per read command (1..8).
- TIMEOUT, 255, max cycles a single transaction may wait (stall plus ack) before abort (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  1  Wishbone address for the command
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_data  out  WORD_BITS  assembled read word; 0 for writes
- rsp_err  out  1  qualifies rsp_valid; 1=timeout abort
- busy  out  1  high in any state other than IDLE
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  strobe
- o_wb_we  out  1  write enable
- o_wb_addr  out  1  address
- o_wb_data  out  8  write data
- i_wb_stall  in  1  responder stall
- i_wb_data  in  1  responder read data
- i_wb_ack  in  1  responder ack

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs 0 except cmd_ready=1; bit counter, timeout counter and shift register cleared. Reset mid-transaction drops cyc/stb immediately, with no response.
- All outputs are registered.
- States: IDLE, REQ, WAIT_ACK, RESP.
- IDLE:
  - cmd_valid && cmd_ready at an edge: latch we/addr/wdata, clear shift register, bit_cnt=0, tmo=0, go to REQ.
  - In the next cycle cyc=stb=1 and we/addr/data are driven.
- REQ:
  - stb held high with stable we/addr/data.
  - On an edge with !i_wb_stall: request accepted; go to WAIT_ACK, stb=0, cyc stays 1, tmo=0.
- WAIT_ACK:
  - i_wb_ack is sampled only in this state.
  - On ack:
    - For a read, shift register bit[bit_cnt] = i_wb_data (first returned bit lands in bit 0, LSB-first).
    - Write, or read with bit_cnt==WORD_BITS-1: go to RESP and drop cyc.
    - Otherwise bit_cnt++, tmo=0, return to REQ (stb=1 next cycle, cyc held continuously across the whole read burst).
- RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_err; next state IDLE.
- Acks in IDLE, REQ or RESP are ignored. The responder must have at least 1 cycle ack latency.
- Timeout:
  - tmo increments every cycle in REQ/WAIT_ACK without accept/ack.
  - Reaching TIMEOUT: cyc=stb=0 next cycle, go to RESP with rsp_err=1.
  - rsp_data holds the bits collected so far; uncollected bits are 0.
  - Accept or ack on the same edge tmo reaches TIMEOUT wins (no error).
- Latency, zero stall, 1-cycle ack:
  - Write: rsp_valid 3 cycles after the accept edge.
  - Read: rsp_valid 2*WORD_BITS+1 cycles after the accept edge.
- A new command is accepted the cycle after RESP at earliest (cmd_ready rises with IDLE).

Test Plan:
- Reset values: assert rst_n=0 mid-read burst -> cyc/stb/rsp_valid drop to 0 asynchronously; cmd_ready=1 after release; no rsp_valid is ever emitted for the aborted command.
- Write: cmd_we=1, addr=0, wdata=8'hA5, no stall, ack 1 cycle after accept -> one stb cycle with we=1, data=A5; rsp_valid at accept+3 with rsp_data=0, rsp_err=0.
- Read burst: cmd_we=0, addr=1; responder returns bits 1,0,1,1,0,0,1,0 -> 8 stb pulses, cyc continuous; rsp_data=8'h4D, rsp_err=0, rsp_valid at accept+17.
- Stall: stall held high 5 cycles on the 3rd read -> stb and address stable through the stall; total latency +5; data still correct.
- Timeout: responder never acks, TIMEOUT=4 -> cyc=0 and rsp_valid with rsp_err=1 after 4 waiting cycles; partial bits retained; cmd_ready=1 the next cycle.
- Back-to-back: write command then read command with cmd_valid held high -> second command accepted the cycle after the first rsp_valid; no overlap of cyc.

Source files
------------

// File: rtl/wb_lfsr_initiator.sv
// rtl/wb_lfsr_initiator.sv - Wishbone pipelined initiator for the LFSR responder port
// One command in flight; a read gathers WORD_BITS single-bit transfers LSB-first.
module wb_lfsr_initiator #(
   parameter int WORD_BITS = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_we,
   input  logic                 cmd_addr,
   input  logic [7:0]           cmd_wdata,
   output logic                 rsp_valid,
   output logic [WORD_BITS-1:0] rsp_data,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 o_wb_cyc,
   output logic                 o_wb_stb,
   output logic                 o_wb_we,
   output logic                 o_wb_addr,
   output logic [7:0]           o_wb_data,
   input  logic                 i_wb_stall,
   input  logic                 i_wb_data,
   input  logic                 i_wb_ack
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam int BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]           state;
   logic [BW-1:0]        bit_cnt;
   logic [7:0]           tmo;
   logic [WORD_BITS-1:0] shift;
   logic [WORD_BITS-1:0] shift_ins;

   // Word as it will look once the bit on the bus this cycle is stored.
   always_comb begin
      shift_ins = shift;
      shift_ins[bit_cnt] = i_wb_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         tmo       <= '0;
         shift     <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= 1'b0;
         o_wb_data <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  o_wb_we   <= cmd_we;
                  o_wb_addr <= cmd_addr;
                  o_wb_data <= cmd_wdata;
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  shift     <= '0;
                  bit_cnt   <= '0;
                  tmo       <= '0;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (!i_wb_stall) begin
                  o_wb_stb <= 1'b0;
                  tmo      <= '0;
                  state    <= S_WAIT;
               end else if (tmo == TMO_LAST) begin
                  o_wb_cyc  <= 1'b0;
                  o_wb_stb  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= shift;
                  state     <= S_RESP;
               end else begin
                  tmo <= tmo + 8'd1;
               end
            end
            S_WAIT: begin
               if (i_wb_ack) begin
                  if (!o_wb_we) shift <= shift_ins;
                  if (o_wb_we || bit_cnt == LAST_BIT) begin
                     o_wb_cyc  <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_data  <= o_wb_we ? '0 : shift_ins;
                     state     <= S_RESP;
                  end else begin
                     // cyc stays high so the whole read burst is one bus cycle
                     bit_cnt  <= bit_cnt + BW'(1);
                     tmo      <= '0;
                     o_wb_stb <= 1'b1;
                     state    <= S_REQ;
                  end
               end else if (tmo == TMO_LAST) begin
                  o_wb_cyc  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= shift;
                  state     <= S_RESP;
               end else begin
                  tmo <= tmo + 8'd1;
               end
            end
            default: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wb_lfsr_initiator.sv
// tb/tb_wb_lfsr_initiator.sv - self-checking bench for wb_lfsr_initiator
module tb_wb_lfsr_initiator;
   localparam int WB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       cmd_valid = 1'b0, cmd_we = 1'b0, cmd_addr = 1'b0;
   logic [7:0] cmd_wdata = 8'h00;
   logic       i_wb_stall, i_wb_data, i_wb_ack;
   logic       sel_t = 1'b0;
   logic       cv_d, cv_t;
   assign cv_d = cmd_valid & ~sel_t;
   assign cv_t = cmd_valid & sel_t;

   logic       d_cmd_ready, d_rsp_valid, d_rsp_err, d_busy, d_cyc, d_stb, d_we, d_addr;
   logic [7:0] d_rsp_data, d_wdat;
   logic       t_cmd_ready, t_rsp_valid, t_rsp_err, t_busy, t_cyc, t_stb, t_we, t_addr;
   logic [7:0] t_rsp_data, t_wdat;

   wb_lfsr_initiator #(.WORD_BITS(WB), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cv_d), .cmd_ready(d_cmd_ready),
      .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(d_rsp_valid), .rsp_data(d_rsp_data), .rsp_err(d_rsp_err), .busy(d_busy),
      .o_wb_cyc(d_cyc), .o_wb_stb(d_stb), .o_wb_we(d_we), .o_wb_addr(d_addr), .o_wb_data(d_wdat),
      .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack));

   wb_lfsr_initiator #(.WORD_BITS(WB), .TIMEOUT(4)) dut_t (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cv_t), .cmd_ready(t_cmd_ready),
      .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err), .busy(t_busy),
      .o_wb_cyc(t_cyc), .o_wb_stb(t_stb), .o_wb_we(t_we), .o_wb_addr(t_addr), .o_wb_data(t_wdat),
      .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack));

   logic       m_stb, m_cyc, m_rsp_valid, m_rsp_err, m_cmd_ready;
   logic [7:0] m_rsp_data;
   assign m_stb       = sel_t ? t_stb : d_stb;
   assign m_cyc       = sel_t ? t_cyc : d_cyc;
   assign m_rsp_valid = sel_t ? t_rsp_valid : d_rsp_valid;
   assign m_rsp_err   = sel_t ? t_rsp_err : d_rsp_err;
   assign m_rsp_data  = sel_t ? t_rsp_data : d_rsp_data;
   assign m_cmd_ready = sel_t ? t_cmd_ready : d_cmd_ready;

   // Per-transfer responder plan: stall cycles, ack latency (0 = never ack), returned bit.
   int   stall_plan [16];
   int   delay_plan [16];
   logic bit_plan   [16];
   int   plan_gen = 0;

   int r_idx = 0, stall_left = 0, ack_cnt = 0, seen_gen = 0;
   bit in_req = 1'b0;

   initial begin
      i_wb_stall = 1'b0;
      i_wb_ack   = 1'b0;
      i_wb_data  = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (seen_gen != plan_gen) begin
            seen_gen = plan_gen;
            r_idx = 0; in_req = 1'b0; ack_cnt = 0; stall_left = 0;
            i_wb_stall = 1'b0;
         end
         i_wb_ack  = 1'b0;
         i_wb_data = 1'b0;
         if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
               i_wb_ack  = 1'b1;
               i_wb_data = bit_plan[r_idx];
               if (r_idx < 15) r_idx++;
            end
         end
         if (m_stb && !in_req) begin
            in_req = 1'b1;
            stall_left = stall_plan[r_idx];
         end
         if (in_req) begin
            if (stall_left > 0) begin
               i_wb_stall = 1'b1;
               stall_left--;
            end else begin
               i_wb_stall = 1'b0;
               in_req = 1'b0;
               ack_cnt = delay_plan[r_idx];
            end
         end
      end
   end

   // Bus protocol monitor on the default instance.
   bit         mon_act = 1'b0;
   logic       exp_we = 1'b0, exp_addr = 1'b0;
   logic [7:0] exp_wd = 8'h00;
   int         proto_err = 0, acc_cnt = 0;
   always @(negedge clk) begin
      if (!sel_t && rst_n) begin
         if (mon_act) begin
            if (!d_cyc && !d_rsp_valid) proto_err++;
            if (d_stb) begin
               if (!d_cyc || d_we != exp_we || d_addr != exp_addr || (exp_we && d_wdat != exp_wd))
                  proto_err++;
               if (!i_wb_stall) acc_cnt++;
            end
         end else if (d_cyc || d_stb) begin
            proto_err++;
         end
      end
   end

   int checks = 0, failures = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_plan(input logic [7:0] bits, input int st_idx, input int st_len, input int dly);
      for (int k = 0; k < 16; k++) begin
         if (k < 8) bit_plan[k] = bits[k];
         else bit_plan[k] = 1'b0;
         stall_plan[k] = (k == st_idx) ? st_len : 0;
         delay_plan[k] = dly;
      end
      plan_gen++;
   endtask

   // Called just after a rising edge with the selected instance idle.
   task automatic run_cmd(input logic we, input logic addr, input logic [7:0] wd,
                          output int lat, output logic [7:0] data, output logic err,
                          output logic cyc_at_rsp, output int perr, output int nacc);
      int p0, a0;
      cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
      exp_we = we; exp_addr = addr; exp_wd = wd;
      p0 = proto_err; a0 = acc_cnt;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      mon_act = 1'b1;
      lat = 0; data = 8'hxx; err = 1'bx; cyc_at_rsp = 1'bx;
      while (lat < 2000) begin
         @(negedge clk);
         lat++;
         if (m_rsp_valid) begin
            data = m_rsp_data; err = m_rsp_err; cyc_at_rsp = m_cyc;
            break;
         end
      end
      mon_act = 1'b0;
      perr = proto_err - p0;
      nacc = acc_cnt - a0;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic       we;
      logic       addr;
      logic [7:0] wd;
      logic [7:0] bits;
      int         st_idx;
      int         st_len;
      logic [7:0] exp_data;
      int         exp_lat;
   } vec_t;
   vec_t vecs [5];

   initial begin
      int         lat, perr, nacc, n, exp_lat, rv_seen;
      logic [7:0] data, exp_data, rbits;
      logic       err, cyc_r, we;

      vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 0,  0, 8'h00, 3};
      vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h4D, 0,  0, 8'h4D, 17};
      vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h4D, 2,  5, 8'h4D, 22};
      vecs[3] = '{1'b1, 1'b1, 8'h3C, 8'h00, 0,  2, 8'h00, 5};
      vecs[4] = '{1'b0, 1'b0, 8'h77, 8'hFF, 7,  1, 8'hFF, 18};

      repeat (3) @(negedge clk);
      check("reset_outputs",
            {d_cmd_ready, d_rsp_valid, d_rsp_err, d_busy, d_cyc, d_stb, d_we, d_addr, d_rsp_data, d_wdat},
            24'h800000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         set_plan(vecs[i].bits, vecs[i].st_idx, vecs[i].st_len, 1);
         run_cmd(vecs[i].we, vecs[i].addr, vecs[i].wd, lat, data, err, cyc_r, perr, nacc);
         check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
         check($sformatf("vec%0d_err", i), err, 1'b0);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_proto", i), perr, 0);
         check($sformatf("vec%0d_nstb", i), nacc, vecs[i].we ? 1 : WB);
         check($sformatf("vec%0d_ready", i), d_cmd_ready, 1'b1);
      end

      // Randomized commands; expected word and latency from the transfer plan.
      for (int i = 0; i < 20; i++) begin
         we = 1'($urandom_range(0, 1));
         n = we ? 1 : WB;
         exp_lat = 1;
         exp_data = 8'h00;
         for (int k = 0; k < 16; k++) begin
            stall_plan[k] = $urandom_range(0, 3);
            delay_plan[k] = $urandom_range(1, 3);
            bit_plan[k]   = 1'($urandom_range(0, 1));
         end
         for (int k = 0; k < n; k++) begin
            exp_lat += stall_plan[k] + 1 + delay_plan[k];
            if (!we) exp_data[k] = bit_plan[k];
         end
         plan_gen++;
         run_cmd(we, 1'($urandom_range(0, 1)), 8'($urandom), lat, data, err, cyc_r, perr, nacc);
         check($sformatf("rnd%0d_data", i), data, exp_data);
         check($sformatf("rnd%0d_err", i), err, 1'b0);
         check($sformatf("rnd%0d_lat", i), lat, exp_lat);
         check($sformatf("rnd%0d_proto", i), perr, 0);
      end

      // Back-to-back: write then read with cmd_valid held high.
      set_plan(8'h00, 0, 0, 1);
      rbits = 8'hB2;
      for (int k = 0; k < 8; k++) bit_plan[k + 1] = rbits[k];
      cmd_we = 1'b1; cmd_addr = 1'b0; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_we = 1'b0; cmd_addr = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!d_rsp_valid && n < 50);
      check("b2b_write_lat", n, 3);
      check("b2b_write_err", d_rsp_err, 1'b0);
      @(negedge clk);
      check("b2b_idle_gap", {d_cmd_ready, d_cyc}, 2'b10);
      @(negedge clk);
      check("b2b_second_accept", {d_cmd_ready, d_cyc, d_stb, d_we, d_addr}, 5'b01101);
      cmd_valid = 1'b0;
      n = 1;
      while (!d_rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("b2b_read_lat", n, 17);
      check("b2b_read_data", d_rsp_data, 8'hB2);
      @(posedge clk); #1;

      // Timeout behaviour on the TIMEOUT=4 instance.
      sel_t = 1'b1;
      set_plan(8'h03, 0, 0, 1);
      delay_plan[2] = 0;
      run_cmd(1'b0, 1'b1, 8'h00, lat, data, err, cyc_r, perr, nacc);
      check("tmo_ack_err", err, 1'b1);
      check("tmo_ack_partial", data, 8'h03);
      check("tmo_ack_lat", lat, 10);
      check("tmo_ack_cyc", cyc_r, 1'b0);
      check("tmo_ack_ready", t_cmd_ready, 1'b1);

      set_plan(8'hFF, 0, 100, 1);
      run_cmd(1'b0, 1'b0, 8'h00, lat, data, err, cyc_r, perr, nacc);
      check("tmo_stall_err", err, 1'b1);
      check("tmo_stall_data", data, 8'h00);
      check("tmo_stall_lat", lat, 5);

      set_plan(8'h00, 0, 3, 1);
      run_cmd(1'b1, 1'b0, 8'h11, lat, data, err, cyc_r, perr, nacc);
      check("edge_accept_err", err, 1'b0);
      check("edge_accept_lat", lat, 6);

      set_plan(8'h00, 0, 0, 4);
      run_cmd(1'b1, 1'b1, 8'h22, lat, data, err, cyc_r, perr, nacc);
      check("edge_ack_err", err, 1'b0);
      check("edge_ack_lat", lat, 6);
      sel_t = 1'b0;

      // Reset in the middle of a read burst.
      set_plan(8'hAA, 0, 0, 1);
      cmd_we = 1'b0; cmd_addr = 1'b1; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_burst_cyc", d_cyc, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_drop", {d_cyc, d_stb, d_rsp_valid, d_busy, d_cmd_ready}, 5'b00001);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rv_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (d_rsp_valid) rv_seen++;
      end
      check("no_rsp_after_reset", rv_seen, 0);
      check("ready_after_reset", d_cmd_ready, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end
endmodule
